instr_fetch: RTL and testbench
==============================

# instr_fetch

Fetch stage of the RV32I single-cycle-memory core. Owns the program counter and drives the address side of `instr_memory_if`, capturing the combinationally returned word the same cycle. Buffers fetched words in a small FIFO and presents them to decode over a valid/ready handshake. Handles control-flow redirects from execute and flags misaligned or out-of-range fetches.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset
- `NUM_INSTR`, 32, instruction memory size in words; legal byte addresses are 0 .. NUM_INSTR*4-4
- `FIFO_DEPTH`, 2, fetch buffer entries (power of two, ≥2)
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `instr_mem_if`  modport `instr_memory_if.cpu`  —  drives `addr` [31:0], samples `instr` [31:0] the same cycle
- `redirect_valid`  in  1  execute requests a PC change
- `redirect_pc`  in  32  redirect target
- `fd_valid`  out  1  head entry valid for decode
- `fd_ready`  in  1  decode accepts head
- `fd_instr`  out  32  instruction word
- `fd_pc`  out  32  PC of `fd_instr`
- `fd_fault`  out  1  entry is a fetch fault (misaligned or out of range)

## Operation
- States: RUN, HALT. Reset → RUN, `pc` = RESET_PC, FIFO empty.
- RUN, no redirect: `instr_mem_if.addr` = `pc`. If FIFO not full, or full and a pop occurs this cycle, push {pc, instr, fault=0} and `pc` ← `pc`+4 (32-bit wrap).
- Fault check on `pc` before push: `pc[1:0]` ≠ 0 or `pc` > NUM_INSTR*4-4 → push {pc, 32'h0000_0013 (NOP), fault=1}, `pc` held, state → HALT.
- HALT: no pushes; FIFO drains normally; leaves HALT only on redirect or reset.
- Redirect (any state): FIFO flushed, `pc` ← `redirect_pc`, state → RUN, no push that cycle. Redirect has priority over push and pop.
- `fd_valid` = FIFO not empty AND NOT `redirect_valid`; a handshake is `fd_valid & fd_ready`. `fd_instr`/`fd_pc`/`fd_fault` come from the FIFO head and are stable while `fd_valid & ~fd_ready`.
- Push on full is allowed only with a simultaneous pop (pass-through on the write pointer); push on empty never bypasses to the output.

## Timing
- Reset values: `fd_valid` 0, `fd_instr` 0, `fd_pc` 0, `fd_fault` 0, `instr_mem_if.addr` = RESET_PC.
- Fetch-to-decode latency: 1 cycle (word fetched in cycle N visible on `fd_*` in N+1).
- Sustained throughput: 1 instruction/cycle with `fd_ready` held high.
- Redirect in cycle N: `fd_valid` low in N, first target word valid in N+2 (fetch in N+1).
- Backpressure: FIFO fills in FIFO_DEPTH cycles; `pc` then stalls, no word lost or duplicated.
- Reset asserted mid-operation: all state returns to reset values asynchronously; in-flight entries discarded.

## Structure
- `rv32i_defs`: add `RV32I_NOP` = 32'h0000_0013 and `fetch_entry_t` struct {pc[31:0], instr[31:0], fault}.
- Add modport `cpu` (output `addr`, input `instr`) to `instr_memory_if`.
- Sub-module `fetch_fifo`: parameterised FIFO_DEPTH of `fetch_entry_t`, push/pop/flush, full/empty, async reset; `instr_fetch` holds PC register, state FSM and fault logic.

## Test plan
- Reset release, memory words 0x00500093, 0x00A00113 at 0x0/0x4, `fd_ready`=1 → cycle 1 `fd_pc`=0x0 `fd_instr`=0x00500093, cycle 2 `fd_pc`=0x4, one per cycle thereafter.
- `fd_ready`=0 for 5 cycles after reset → FIFO holds PCs 0x0, 0x4; `addr` stalls at 0x8; on release PCs 0x0, 0x4, 0x8 emerge in order, none lost or repeated.
- Redirect to 0x40 with FIFO full → `fd_valid`=0 that cycle, next `fd_pc`=0x40 two cycles later, stale entries never emerge.
- Redirect to 0x42 → one entry `fd_pc`=0x42, `fd_instr`=0x00000013, `fd_fault`=1, then `fd_valid` stays 0 until redirect to 0x0 resumes fetch.
- NUM_INSTR=32, sequential run from 0x78 → entries 0x78, 0x7C normal, entry 0x80 with `fd_fault`=1, then HALT.
- Assert `rst` mid-stream with FIFO non-empty → outputs zero immediately, `addr`=RESET_PC; after release fetch restarts at RESET_PC.

Source files
------------

// File: rtl/rv32i_defs.sv
// Shared RV32I definitions for the front end: canonical NOP, fetch buffer entry and fetch FSM states.
package rv32i_defs;

    localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } fetch_entry_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/instr_memory_if.sv
// Instruction memory port: the CPU drives a byte address and the memory returns the word combinationally.
interface instr_memory_if;
    logic [31:0] addr;
    logic [31:0] instr;

    modport cpu (output addr, input instr);
    modport mem (input addr, output instr);
endinterface

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetch entries with flush; a push while full is accepted only alongside a pop.
module fetch_fifo
    import rv32i_defs::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wr_entry,
    output fetch_entry_t rd_entry,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   entries_reg [DEPTH];
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  rd_ptr_reg;
    logic [AW:0]    count_reg;
    logic           do_push;
    logic           do_pop;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_pop  = pop & ~empty & ~flush;
    // When full, the write slot equals the head slot; the head is read out before it is overwritten.
    assign do_push = push & (~full | do_pop) & ~flush;

    assign rd_entry = empty ? '0 : entries_reg[rd_ptr_reg];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    entries_reg[gi] <= '0;
                end else if (do_push && (wr_ptr_reg == AW'(gi))) begin
                    entries_reg[gi] <= wr_entry;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
            else if (do_pop && !do_push) count_reg <= count_reg - 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// RV32I fetch stage: PC register, RUN/HALT control, fault detection and a buffered valid/ready path to decode.
module instr_fetch
    import rv32i_defs::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          NUM_INSTR  = 32,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    instr_memory_if.cpu        instr_mem_if,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               fd_valid,
    input  logic               fd_ready,
    output logic [31:0]        fd_instr,
    output logic [31:0]        fd_pc,
    output logic               fd_fault
);
    localparam logic [31:0] LAST_ADDR = 32'(NUM_INSTR * 4 - 4);

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic         fifo_full, fifo_empty;
    logic         push, pop, pc_fault;
    fetch_entry_t push_entry, head_entry;

    assign instr_mem_if.addr = pc_reg;
    assign pc_fault          = (pc_reg[1:0] != 2'b00) || (pc_reg > LAST_ADDR);

    assign fd_valid = ~fifo_empty & ~redirect_valid;
    assign pop      = fd_valid & fd_ready;
    assign fd_instr = head_entry.instr;
    assign fd_pc    = head_entry.pc;
    assign fd_fault = head_entry.fault;

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        push             = 1'b0;
        push_entry.pc    = pc_reg;
        push_entry.instr = pc_fault ? RV32I_NOP : instr_mem_if.instr;
        push_entry.fault = pc_fault;
        if (redirect_valid) begin
            state_next = RUN;
            pc_next    = redirect_pc;
        end else if (state_reg == RUN && (!fifo_full || pop)) begin
            push = 1'b1;
            // A faulting PC is reported once and then held until execute steers us elsewhere.
            if (pc_fault) state_next = HALT;
            else          pc_next    = pc_reg + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= RUN;
            pc_reg    <= RESET_PC;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .flush    (redirect_valid),
        .wr_entry (push_entry),
        .rd_entry (head_entry),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a queue-based reference model checked every cycle plus literal spot checks.
module tb_instr_fetch;
    localparam int          NUM    = 32;
    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        fd_ready = 1'b1;
    logic        fd_valid, fd_fault;
    logic [31:0] fd_instr, fd_pc;
    logic [31:0] mem [NUM];

    int total = 0;
    int bad   = 0;

    instr_memory_if imem ();
    assign imem.instr = (imem.addr[31:2] < NUM) ? mem[imem.addr[6:2]] : 32'hDEAD_BEEF;

    instr_fetch #(
        .RESET_PC   (RST_PC),
        .NUM_INSTR  (NUM),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .instr_mem_if   (imem),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fd_valid       (fd_valid),
        .fd_ready       (fd_ready),
        .fd_instr       (fd_instr),
        .fd_pc          (fd_pc),
        .fd_fault       (fd_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of what decode should see, the next fetch address and a halted flag.
    exp_t        q[$];
    logic [31:0] m_pc   = RST_PC;
    bit          m_halt = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_pc   = RST_PC;
            m_halt = 0;
        end else if (redirect_valid) begin
            q.delete();
            m_pc   = redirect_pc;
            m_halt = 0;
        end else begin
            if (q.size() > 0 && fd_ready) void'(q.pop_front());
            if (!m_halt && q.size() < DEPTH) begin
                if ((m_pc % 4) != 0 || m_pc > NUM * 4 - 4) begin
                    q.push_back('{m_pc, NOP, 1'b1});
                    m_halt = 1;
                end else begin
                    q.push_back('{m_pc, mem[m_pc / 4], 1'b0});
                    m_pc = m_pc + 4;
                end
            end
        end
    end

    always @(negedge clk) begin
        bit ev;
        ev = (q.size() > 0) && !redirect_valid && !rst;
        check("model_valid", {31'b0, fd_valid}, {31'b0, ev});
        check("model_addr", imem.addr, m_pc);
        if (ev) begin
            check("model_pc", fd_pc, q[0].pc);
            check("model_instr", fd_instr, q[0].instr);
            check("model_fault", {31'b0, fd_fault}, {31'b0, q[0].fault});
        end
        $display("cycle t=%0t valid=%0b pc=%08h instr=%08h fault=%0b addr=%08h",
                 $time, fd_valid, fd_pc, fd_instr, fd_fault, imem.addr);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic expect_head(input string name, input logic [31:0] pc,
                               input logic [31:0] instr, input logic fault);
        check({name, "_valid"}, {31'b0, fd_valid}, 32'd1);
        check({name, "_pc"}, fd_pc, pc);
        check({name, "_instr"}, fd_instr, instr);
        check({name, "_fault"}, {31'b0, fd_fault}, {31'b0, fault});
    endtask

    initial begin
        for (int i = 0; i < NUM; i++) mem[i] = 32'h1000_0000 + 32'(i * 32'h111);
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h00A0_0113;

        // Reset state
        #1 rst = 1'b1;
        #2;
        check("rst_valid", {31'b0, fd_valid}, 32'd0);
        check("rst_pc", fd_pc, 32'h0);
        check("rst_instr", fd_instr, 32'h0);
        check("rst_addr", imem.addr, RST_PC);
        step();
        step();
        rst = 1'b0;

        // Streaming from reset with decode always ready
        step();
        expect_head("stream0", 32'h0, 32'h0050_0093, 1'b0);
        step();
        expect_head("stream1", 32'h4, 32'h00A0_0113, 1'b0);
        step();
        expect_head("stream2", 32'h8, mem[2], 1'b0);

        // Backpressure: FIFO fills with 0x0/0x4 and the PC stalls at 0x8
        redirect_to(32'h0);
        fd_ready = 1'b0;
        repeat (5) step();
        expect_head("bp_hold", 32'h0, 32'h0050_0093, 1'b0);
        check("bp_addr", imem.addr, 32'h8);
        fd_ready = 1'b1;
        step();
        expect_head("bp_rel1", 32'h4, 32'h00A0_0113, 1'b0);
        step();
        expect_head("bp_rel2", 32'h8, mem[2], 1'b0);

        // Redirect with the FIFO full: stale entries must vanish
        fd_ready = 1'b0;
        repeat (3) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        #1;
        check("redir_valid_low", {31'b0, fd_valid}, 32'd0);
        step();
        redirect_valid = 1'b0;
        fd_ready = 1'b1;
        check("redir_gap", {31'b0, fd_valid}, 32'd0);
        step();
        expect_head("redir_tgt", 32'h40, mem[16], 1'b0);
        step();

        // Misaligned target: one fault entry then silence until a redirect
        redirect_to(32'h42);
        step();
        expect_head("misal", 32'h42, NOP, 1'b1);
        repeat (3) step();
        check("halt_valid", {31'b0, fd_valid}, 32'd0);
        check("halt_addr", imem.addr, 32'h42);
        redirect_to(32'h0);
        step();
        expect_head("resume", 32'h0, 32'h0050_0093, 1'b0);

        // Run off the end of instruction memory
        redirect_to(32'h78);
        step();
        expect_head("end0", 32'h78, mem[30], 1'b0);
        step();
        expect_head("end1", 32'h7C, mem[31], 1'b0);
        step();
        expect_head("end2", 32'h80, NOP, 1'b1);
        step();
        check("end_halt", {31'b0, fd_valid}, 32'd0);

        // Asynchronous reset in mid-stream
        redirect_to(32'h10);
        fd_ready = 1'b0;
        step();
        step();
        #2 rst = 1'b1;
        #1;
        check("arst_valid", {31'b0, fd_valid}, 32'd0);
        check("arst_pc", fd_pc, 32'h0);
        check("arst_fault", {31'b0, fd_fault}, 32'd0);
        check("arst_addr", imem.addr, RST_PC);
        step();
        rst = 1'b0;
        fd_ready = 1'b1;
        step();
        expect_head("arst_restart", RST_PC, 32'h0050_0093, 1'b0);
        step();
        expect_head("arst_next", 32'h4, 32'h00A0_0113, 1'b0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
